// File: rtl/mem_arb_pkg.sv
// Shared constants for the cache-side memory request arbiter.
// FSM encoding, arbitration mode selectors and the default transfer size.
package mem_arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE = 2'd0;
    localparam arb_state_t ST_BUSY = 2'd1;
    localparam arb_state_t ST_TURN = 2'd2;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Single cache-port bus between the arbiter and axi_interface.
// master = arbiter side, slave = axi_interface side.
interface mem_req_arbiter_if #(
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
);
    logic [A_WIDTH-1:0] mem_a;
    logic               mem_access;
    logic               mem_write;
    logic [1:0]         mem_size;
    logic [3:0]         mem_sel;
    logic [D_WIDTH-1:0] mem_st_data;
    logic               mem_ready;
    logic [D_WIDTH-1:0] mem_data;

    modport master (
        output mem_a, mem_access, mem_write,
        output mem_size, mem_sel, mem_st_data,
        input  mem_ready, mem_data
    );

    modport slave (
        input  mem_a, mem_access, mem_write,
        input  mem_size, mem_sel, mem_st_data,
        output mem_ready, mem_data
    );
endinterface

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational winner picker: rotate the request vector by the base
// pointer, priority-encode, then rotate the index back.
module rr_picker #(
    parameter int N  = 3,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] base,
    input  logic          mode,
    output logic [N-1:0]  win_oh,
    output logic [PW-1:0] win_idx
);
    logic [PW-1:0]  start;
    logic [PW-1:0]  off;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [PW:0]    sum;

    // Fixed priority is round-robin pinned at base 0.
    assign start = mode ? base : '0;
    assign dbl   = {req, req};
    assign rot   = dbl[start +: N];

    always_comb begin
        off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (PW+1)'(N))
            win_idx = PW'(sum - (PW+1)'(N));
        else
            win_idx = sum[PW-1:0];
        win_oh = (|req) ? (N'(1) << win_idx) : '0;
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel cache request arbiter feeding the axi_interface cache port.
// Latches the winning request for the whole transaction, then idles one cycle.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH  = 3,
    parameter int RR_MODE = 0,
    parameter int A_WIDTH = 32,
    parameter int D_WIDTH = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [NUM_CH-1:0]         req_access,
    input  logic [NUM_CH-1:0]         req_write,
    input  logic [NUM_CH*A_WIDTH-1:0] req_addr,
    input  logic [NUM_CH*2-1:0]       req_size,
    input  logic [NUM_CH*4-1:0]       req_sel,
    input  logic [NUM_CH*D_WIDTH-1:0] req_wdata,
    output logic [NUM_CH-1:0]         req_ready,
    output logic [D_WIDTH-1:0]        req_rdata,
    mem_req_arbiter_if.master         mem,
    output logic [NUM_CH-1:0]         grant,
    output logic                      busy
);
    localparam int PW = $clog2(NUM_CH);
    localparam logic MODE = (RR_MODE == ARB_RR);
    localparam logic [PW-1:0] LAST = PW'(NUM_CH - 1);

    arb_state_t          state;
    logic [PW-1:0]       rr_ptr;
    logic [PW-1:0]       own_idx;
    logic [NUM_CH-1:0]   own_oh;
    logic [NUM_CH-1:0]   win_oh;
    logic [PW-1:0]       win_idx;

    logic [A_WIDTH-1:0]  lat_addr;
    logic                lat_write;
    logic [1:0]          lat_size;
    logic [3:0]          lat_sel;
    logic [D_WIDTH-1:0]  lat_wdata;

    logic [A_WIDTH-1:0]  sel_addr;
    logic                sel_write;
    logic [1:0]          sel_size;
    logic [3:0]          sel_sel;
    logic [D_WIDTH-1:0]  sel_wdata;

    rr_picker #(
        .N  (NUM_CH),
        .PW (PW)
    ) u_picker (
        .req     (req_access),
        .base    (rr_ptr),
        .mode    (MODE),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_comb begin
        sel_addr  = '0;
        sel_write = 1'b0;
        sel_size  = '0;
        sel_sel   = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (win_oh[i]) begin
                sel_addr  = req_addr[i*A_WIDTH +: A_WIDTH];
                sel_write = req_write[i];
                sel_size  = req_size[i*2 +: 2];
                sel_sel   = req_sel[i*4 +: 4];
                sel_wdata = req_wdata[i*D_WIDTH +: D_WIDTH];
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            own_idx   <= '0;
            own_oh    <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_sel   <= '0;
            lat_wdata <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (|req_access) begin
                        state     <= ST_BUSY;
                        own_idx   <= win_idx;
                        own_oh    <= win_oh;
                        lat_addr  <= sel_addr;
                        lat_write <= sel_write;
                        lat_size  <= sel_size;
                        lat_sel   <= sel_sel;
                        lat_wdata <= sel_wdata;
                    end
                end
                ST_BUSY: begin
                    if (mem.mem_ready) begin
                        state  <= ST_TURN;
                        own_oh <= '0;
                        if (MODE)
                            rr_ptr <= (own_idx == LAST) ? '0 : own_idx + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (state == ST_BUSY);
    assign grant           = busy ? own_oh : '0;
    assign req_ready       = (busy && mem.mem_ready) ? own_oh : '0;
    assign req_rdata       = mem.mem_data;

    assign mem.mem_access  = busy;
    assign mem.mem_a       = lat_addr;
    assign mem.mem_write   = lat_write;
    assign mem.mem_size    = lat_size;
    assign mem.mem_sel     = lat_sel;
    assign mem.mem_st_data = lat_wdata;
endmodule
